// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C subsystem.
//   arb_state_t : states of the master arbiter (i2c_master_arbiter)
//   i2c_state_t : bus-level phases of the i2c_master
//   I2C_ADDR_W  : 7-bit slave address width
//   I2C_DATA_W  : byte width
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_DRAIN = 3'd4
    } arb_state_t;

    typedef enum logic [2:0] {
        I2C_IDLE  = 3'd0,
        I2C_START = 3'd1,
        I2C_ADDR  = 3'd2,
        I2C_DATA  = 3'd3,
        I2C_ACK   = 3'd4,
        I2C_STOP  = 3'd5
    } i2c_state_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set bit of req_i found
// searching upward from ptr_i, wrapping modulo N.
//   req_i    : request vector
//   ptr_i    : search start index (must be < N)
//   gnt_oh_o : one-hot selection (zero when no request)
//   idx_o    : binary index of the selection
//   any_o    : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    always_comb begin
        gnt_oh_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum      = '0;
        k        = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit keeps ptr+i from overflowing before the wrap.
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k = sum[IW-1:0];
            if (!any_o && req_i[k]) begin
                any_o       = 1'b1;
                gnt_oh_o[k] = 1'b1;
                idx_o       = k;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_master_arbiter
// Shares one i2c_master among NUM_REQ requesters issuing single-byte
// transactions. Round-robin grant, command hand-off to the master, result
// return to the winner, and a watchdog that recovers from a stalled bus.
//   clk_i, rst_ni        : system clock, async active-low reset
//   req_i/rw_i           : per-requester request and direction (1 = read)
//   addr_i/data_i        : packed per-requester address / write data
//   gnt_o                : one-hot grant, ISSUE through RESP
//   done_o               : one-cycle completion pulse to the winner
//   data_o/nack_o/timeout_o : result, valid while done_o is nonzero
//   busy_o               : arbiter not idle
//   mst_en_o/rw/addr/data: command to the i2c_master
//   mst_busy_i/done_i/ack_i/data_i : status from the i2c_master
// -----------------------------------------------------------------------------
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = I2C_ADDR_W,
    parameter int DATA_W      = I2C_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rw_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      nack_o,
    output logic                      timeout_o,
    output logic                      busy_o,
    output logic                      mst_en_o,
    output logic                      mst_rw_o,
    output logic [ADDR_W-1:0]         mst_addr_o,
    output logic [DATA_W-1:0]         mst_data_o,
    input  logic                      mst_busy_i,
    input  logic                      mst_done_i,
    input  logic                      mst_ack_i,
    input  logic [DATA_W-1:0]         mst_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 nack_q, nack_d;
    logic                 tmo_q, tmo_d;
    logic                 en_q, en_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            tmo_q   <= tmo_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        tmo_d   = tmo_q;
        en_d    = en_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_ISSUE;
                    win_d   = pick_idx;
                    gnt_d   = pick_oh;
                    en_d    = 1'b1;
                    rw_d    = rw_i[pick_idx];
                    addr_d  = addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = data_i[int'(pick_idx)*DATA_W +: DATA_W];
                    wd_d    = '0;
                end
            end

            ARB_ISSUE, ARB_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // Completion takes priority over watchdog expiry on the same cycle.
                if (mst_done_i) begin
                    state_d = ARB_RESP;
                    en_d    = 1'b0;
                    done_d  = gnt_q;
                    rdata_d = rw_q ? mst_data_i : '0;
                    nack_d  = ~mst_ack_i;
                    tmo_d   = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ARB_RESP;
                    en_d    = 1'b0;
                    done_d  = gnt_q;
                    rdata_d = '0;
                    nack_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else if (state_q == ARB_ISSUE && mst_busy_i) begin
                    state_d = ARB_WAIT;
                    en_d    = 1'b0;
                end
            end

            ARB_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                // A timed-out master may still own the bus; hold off new grants.
                state_d = (tmo_q && mst_busy_i) ? ARB_DRAIN : ARB_IDLE;
            end

            ARB_DRAIN: begin
                if (!mst_busy_i) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign data_o     = rdata_q;
    assign nack_o     = nack_q;
    assign timeout_o  = tmo_q;
    assign busy_o     = (state_q != ARB_IDLE);
    assign mst_en_o   = en_q;
    assign mst_rw_o   = rw_q;
    assign mst_addr_o = addr_q;
    assign mst_data_o = wdata_q;

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_master between NUM_REQ requesters, each requesting single-byte transactions (address, direction, write data).
- Round-robin arbitration; the block drives the master's command inputs, waits for completion, and returns read data and ACK/NACK status to the winning requester.
- Watchdog timeout recovers from a stalled bus.
- Sits between the system-clock-domain clients and the i2c_master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 7, I2C slave address width
- DATA_W, 8, data byte width
- TIMEOUT_CYC, 4096, clk_i cycles allowed from ISSUE entry to mst_done_i

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  per-requester request; held high until that requester's done_o
- rw_i  in  NUM_REQ  per-requester direction, 1=read, 0=write
- addr_i  in  NUM_REQ*ADDR_W  packed per-requester slave addresses, requester k at [k*ADDR_W +: ADDR_W]
- data_i  in  NUM_REQ*DATA_W  packed per-requester write data
- gnt_o  out  NUM_REQ  one-hot grant, high from ISSUE through RESP
- done_o  out  NUM_REQ  one-cycle completion pulse to the winner
- data_o  out  DATA_W  read data, valid while done_o is nonzero
- nack_o  out  1  slave NACKed, valid while done_o is nonzero
- timeout_o  out  1  watchdog expired, valid while done_o is nonzero
- busy_o  out  1  state is not IDLE
- mst_en_o  out  1  command strobe to the master
- mst_rw_o  out  1  latched direction
- mst_addr_o  out  ADDR_W  latched address
- mst_data_o  out  DATA_W  latched write data
- mst_busy_i  in  1  master is executing a transaction
- mst_done_i  in  1  master completion pulse
- mst_ack_i  in  1  1 = slave ACKed all bytes
- mst_data_i  in  DATA_W  master read data

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, all outputs 0, watchdog 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any req_i is high, pick the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - On the next edge: latch that requester's rw/addr/data into mst_*_o, set gnt_o one-hot and mst_en_o=1, clear the watchdog, go to ISSUE.
- ISSUE: hold mst_en_o=1 until mst_busy_i=1.
  - Then mst_en_o=0 and go to WAIT.
  - If mst_busy_i and mst_done_i are high together, go directly to RESP.
- WAIT: on mst_done_i, register data_o=mst_data_i (reads only, else 0), nack_o=~mst_ack_i, timeout_o=0; go to RESP.
- Watchdog:
  - Increments every cycle in ISSUE and WAIT.
  - At TIMEOUT_CYC-1 without mst_done_i: mst_en_o=0, timeout_o=1, nack_o=1, data_o=0; go to RESP.
  - If mst_done_i arrives in the same cycle, done wins and timeout_o=0.
- RESP (exactly 1 cycle): done_o[winner]=1, rr pointer = (winner+1) mod NUM_REQ, gnt_o cleared on exit.
  - Next state is DRAIN if timeout_o=1 and mst_busy_i=1, else IDLE.
- DRAIN: wait for mst_busy_i=0, then go to IDLE. No new grant while the master is still busy.
- Latency: req_i to mst_en_o is 1 cycle; mst_done_i to done_o is 1 cycle; RESP back to the next gnt_o is at least 1 cycle.
- Boundary cases:
  - Winner drops req_i mid-transaction: ignored, the transaction completes and done_o still pulses.
  - Other requesters' req/addr/data changes after the latch have no effect on the current transaction.
  - Only one requester active: it is granted back-to-back with a 1-cycle IDLE gap.
  - req_i all zero: remain in IDLE, pointer unchanged.
  - Reset mid-transaction: immediate return to reset values; master recovery is the master's responsibility.
- Invariants: $onehot0(gnt_o), $onehot0(done_o), done_o implies gnt_o, mst_en_o implies state ISSUE.

Decomposition:
- Package i2c_pkg: arb_state_t enum (IDLE, ISSUE, WAIT, RESP, DRAIN), shared with the existing I2C state typedef; I2C_ADDR_W=7, I2C_DATA_W=8 constants.
- Sub-module rr_pick: combinational round-robin first-set search over NUM_REQ bits starting at a pointer, returning one-hot and index. Reusable and formally checkable on its own.

Test Plan:
- Single write: req_i=0001, addr0=0x50, data0=0xA5, rw0=0; master busy 3 cycles later, done with ack=1 -> mst_addr_o=0x50, mst_data_o=0xA5, done_o=0001, nack_o=0, timeout_o=0.
- Read with NACK: req_i=0100, rw2=1, addr2=0x3C; master done ack=0, mst_data_i=0xFF -> done_o=0100, nack_o=1, data_o=0xFF.
- Fairness: req_i=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester granted twice before all others.
- Timeout: TIMEOUT_CYC=16, master asserts busy but never done -> done_o pulses exactly 16 cycles after ISSUE entry with timeout_o=1; state holds in DRAIN until busy falls; no grant while busy.
- Simultaneous done and expiry on the same cycle -> timeout_o=0, nack_o reflects ack.
- Reset asserted in WAIT with req_i=0011 -> outputs 0 immediately; after release, requester 0 is granted first (pointer 0).
